// File: rtl/reset_sequencer.sv
// Releases active-low domain resets one at a time in index order after a hold period,
// with a fixed gap between releases; a level soft request re-runs the sequence.
module reset_sequencer #(
  parameter int OUTPUTS = 4,
  parameter int HOLD    = 8,
  parameter int DELAY   = 16
) (
  input  logic               CLK_I,
  input  logic               RST_I,
  input  logic               SRST_REQ_I,
  output logic [OUTPUTS-1:0] NRST_O,
  output logic               READY_O,
  output logic               BUSY_O
);

  localparam int MAXC = (HOLD > DELAY) ? HOLD : DELAY;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int IW   = $clog2(OUTPUTS + 1);

  localparam logic [1:0] ST_HOLD    = 2'd0;
  localparam logic [1:0] ST_RELEASE = 2'd1;
  localparam logic [1:0] ST_RUN     = 2'd2;

  logic [1:0]         state, state_n;
  logic [CW-1:0]      cnt, cnt_n;
  logic [IW-1:0]      idx, idx_n;
  logic [OUTPUTS-1:0] nrst, nrst_n;
  logic               ready, ready_n;
  logic               busy;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    nrst_n  = nrst;
    ready_n = ready;
    // A soft request wins over any release that would land on the same edge.
    if (SRST_REQ_I) begin
      state_n = ST_HOLD;
      cnt_n   = '0;
      idx_n   = '0;
      nrst_n  = '0;
      ready_n = 1'b0;
    end else begin
      case (state)
        ST_HOLD: begin
          if (cnt == CW'(HOLD - 1)) begin
            nrst_n[0] = 1'b1;
            cnt_n     = '0;
            idx_n     = IW'(1);
            if (OUTPUTS == 1) begin
              state_n = ST_RUN;
              ready_n = 1'b1;
            end else begin
              state_n = ST_RELEASE;
            end
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
        ST_RELEASE: begin
          if (cnt == CW'(DELAY - 1)) begin
            for (int i = 0; i < OUTPUTS; i++) begin
              if (idx == IW'(i)) nrst_n[i] = 1'b1;
            end
            idx_n = idx + IW'(1);
            cnt_n = '0;
            if (idx == IW'(OUTPUTS - 1)) begin
              state_n = ST_RUN;
              ready_n = 1'b1;
            end
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
        ST_RUN: begin
          cnt_n = cnt;
        end
        default: begin
          state_n = ST_HOLD;
          cnt_n   = '0;
          idx_n   = '0;
          nrst_n  = '0;
          ready_n = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state <= ST_HOLD;
      cnt   <= '0;
      idx   <= '0;
      nrst  <= '0;
      ready <= 1'b0;
      busy  <= 1'b1;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      nrst  <= nrst_n;
      ready <= ready_n;
      busy  <= ~ready_n;
    end
  end

  assign NRST_O  = nrst;
  assign READY_O = ready;
  assign BUSY_O  = busy;

endmodule
